dma_timing_ctrl_n: RTL and testbench

DMA_TIMING_CTRL_N -- requirements
Module: dma_timing_ctrl_n

---
 rtl/dma_timing_pkg.sv | 35 +++
 rtl/dma_prio_arb.sv | 43 ++++
 rtl/dma_timing_ctrl_n.sv | 136 +++++++++++++
 tb/tb_dma_timing_ctrl_n.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dma_timing_pkg.sv
// Shared types for the DMA timing controller: one-hot state encodings,
// transfer-type encodings and the per-channel configuration record.
package dma_timing_pkg;

  typedef enum logic [5:0] {
    ST_SI = 6'b000001,
    ST_SO = 6'b000010,
    ST_S1 = 6'b000100,
    ST_S2 = 6'b001000,
    ST_S3 = 6'b010000,
    ST_S4 = 6'b100000
  } state_e;

  typedef enum logic [1:0] {
    XF_VERIFY     = 2'b00,
    XF_WRITE      = 2'b01,
    XF_READ       = 2'b10,
    XF_VERIFY_ALT = 2'b11
  } xfer_e;

  typedef struct packed {
    xfer_e xfer;
    logic  masked;
  } ch_cfg_t;

  // Returns {ior_n, iow_n, memr_n, memw_n}; rd covers S2/S3, wr covers S3 only.
  function automatic logic [3:0] strobe_pattern(input xfer_e xf, input logic rd, input logic wr);
    logic is_wr;
    logic is_rd;
    is_wr = (xf == XF_WRITE);
    is_rd = (xf == XF_READ);
    return {~(rd & is_wr), ~(wr & is_rd), ~(rd & is_rd), ~(wr & is_wr)};
  endfunction

endpackage

// File: rtl/dma_prio_arb.sv
// Channel priority arbiter: pending vector in, one-hot grant out.
// Build option ROTATING_PRIORITY_EN enables round-robin; otherwise channel 0 is highest.
module dma_prio_arb #(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] pending,
  input  logic              advance,
  input  logic [SEL_W-1:0]  served_idx,
  output logic [NUM_CH-1:0] grant
);

`ifdef ROTATING_PRIORITY_EN
  logic [SEL_W-1:0]  ptr_q;
  logic [NUM_CH-1:0] rot_req;
  logic [NUM_CH-1:0] rot_gnt;

  // Rotate so ptr_q sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    rot_req = NUM_CH'({pending, pending} >> ptr_q);
    rot_gnt = rot_req & (~rot_req + NUM_CH'(1));
    grant   = NUM_CH'(({rot_gnt, rot_gnt} << ptr_q) >> NUM_CH);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (served_idx == SEL_W'(NUM_CH - 1)) ? '0 : served_idx + SEL_W'(1);
    end
  end
`else
  logic unused_arb;
  assign unused_arb = ^{clk, reset_n, advance, served_idx};

  always_comb begin
    grant = pending & (~pending + NUM_CH'(1));
  end
`endif

endmodule

// File: rtl/dma_timing_ctrl_n.sv
// 8237-style DMA channel timing controller (SI/SO/S1..S4), registered outputs.
// Build option ROTATING_PRIORITY_EN selects round-robin channel priority.
module dma_timing_ctrl_n
  import dma_timing_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cs_n,
  input  logic                hlda,
  input  logic                ready,
  input  logic [NUM_CH-1:0]   dreq,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [2*NUM_CH-1:0] xfer_type,
  input  logic                cnt_ld,
  input  logic [SEL_W-1:0]    cnt_sel,
  input  logic [CNT_W-1:0]    cnt_data,
  output logic                hrq,
  output logic                aen,
  output logic                adstb,
  output logic                tc,
  output logic                ior_n,
  output logic                iow_n,
  output logic                memr_n,
  output logic                memw_n,
  output logic [NUM_CH-1:0]   dack,
  output logic [5:0]          state
);

  state_e            state_q, state_d;
  ch_cfg_t           cfg [NUM_CH];
  logic [NUM_CH-1:0] pending, grant, done_q;
  logic [SEL_W-1:0]  grant_idx, win_idx_q, win_sel;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_eff;
  logic              in_xfer_d, tc_d;
  logic [3:0]        strb_d;

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cfg[i]     = '{xfer: xfer_e'(xfer_type[2*i +: 2]), masked: ch_mask[i]};
      pending[i] = dreq[i] & ~cfg[i].masked & ~done_q[i];
    end
  end

  dma_prio_arb #(.NUM_CH(NUM_CH)) u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .pending    (pending),
    .advance    (state_q == ST_S4),
    .served_idx (win_idx_q),
    .grant      (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant[i]) grant_idx = SEL_W'(i);
    end
    win_sel = (state_q == ST_SO) ? grant_idx : win_idx_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SI: if (!cs_n && pending != '0) state_d = ST_SO;
      ST_SO: begin
        if (cs_n || pending == '0) state_d = ST_SI;
        else if (hlda)             state_d = ST_S1;
      end
      ST_S1: state_d = hlda ? ST_S2 : ST_SI;
      ST_S2: state_d = hlda ? ST_S3 : ST_SI;
      ST_S3: begin
        if (!hlda)     state_d = ST_SI;
        else if (ready) state_d = ST_S4;
      end
      default: state_d = ST_SI;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with STATE.
  // A same-cycle load of the winner's counter is folded in so TC matches the S4 count.
  always_comb begin
    in_xfer_d = (state_d == ST_S1) || (state_d == ST_S2) ||
                (state_d == ST_S3) || (state_d == ST_S4);
    strb_d    = strobe_pattern(cfg[win_sel].xfer,
                               (state_d == ST_S2) || (state_d == ST_S3),
                               (state_d == ST_S3));
    cnt_eff   = (cnt_ld && cnt_sel == win_sel) ? cnt_data : cnt_q[win_sel];
    tc_d      = (state_d == ST_S4) && (cnt_eff == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q                          <= ST_SI;
      win_idx_q                        <= '0;
      hrq                              <= 1'b0;
      aen                              <= 1'b0;
      adstb                            <= 1'b0;
      tc                               <= 1'b0;
      dack                             <= '0;
      {ior_n, iow_n, memr_n, memw_n}   <= '1;
    end else begin
      state_q <= state_d;
      if (state_q == ST_SO && state_d == ST_S1) win_idx_q <= grant_idx;
      hrq                              <= (state_d != ST_SI);
      aen                              <= in_xfer_d;
      adstb                            <= (state_d == ST_S1);
      tc                               <= tc_d;
      dack                             <= in_xfer_d ? (NUM_CH'(1) << win_sel) : '0;
      {ior_n, iow_n, memr_n, memw_n}   <= strb_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!reset_n) begin
        cnt_q[i]  <= '0;
        done_q[i] <= 1'b0;
      end else if (cnt_ld && cnt_sel == SEL_W'(i)) begin
        cnt_q[i]  <= cnt_data;
        done_q[i] <= 1'b0;
      end else if (state_q == ST_S4 && win_idx_q == SEL_W'(i)) begin
        cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        if (tc) done_q[i] <= 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_dma_timing_ctrl_n.sv
// Directed self-checking bench for dma_timing_ctrl_n (default or ROTATING_PRIORITY_EN build).
module tb_dma_timing_ctrl_n;

  localparam logic [5:0] SI = 6'b000001;
  localparam logic [5:0] SO = 6'b000010;
  localparam logic [5:0] S1 = 6'b000100;
  localparam logic [5:0] S2 = 6'b001000;
  localparam logic [5:0] S3 = 6'b010000;
  localparam logic [5:0] S4 = 6'b100000;

`ifdef ROTATING_PRIORITY_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n, cs_n, hlda, ready;
  logic [3:0] dreq, ch_mask;
  logic [7:0] xfer_type;
  logic       cnt_ld;
  logic [1:0] cnt_sel;
  logic [15:0] cnt_data;
  logic       hrq, aen, adstb, tc, ior_n, iow_n, memr_n, memw_n;
  logic [3:0] dack;
  logic [5:0] state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dma_timing_ctrl_n #(.NUM_CH(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .hlda(hlda), .ready(ready),
    .dreq(dreq), .ch_mask(ch_mask), .xfer_type(xfer_type),
    .cnt_ld(cnt_ld), .cnt_sel(cnt_sel), .cnt_data(cnt_data),
    .hrq(hrq), .aen(aen), .adstb(adstb), .tc(tc),
    .ior_n(ior_n), .iow_n(iow_n), .memr_n(memr_n), .memw_n(memw_n),
    .dack(dack), .state(state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {ior_n, iow_n, memr_n, memw_n} for a transfer type in S2 / S3.
  function automatic logic [3:0] exp_strb(input logic [1:0] ty, input bit in_s3);
    case (ty)
      2'b01:   return in_s3 ? 4'b0110 : 4'b0111;
      2'b10:   return in_s3 ? 4'b1001 : 4'b1101;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic load(input logic [1:0] ch, input logic [15:0] val);
    cnt_ld = 1'b1; cnt_sel = ch; cnt_data = val;
    tick();
    cnt_ld = 1'b0;
  endtask

  // One full SI->SO->S1->S2->S3->S4->SI pass starting in SI with the channel pending.
  task automatic xfer(input string tag, input logic [3:0] d, input logic [1:0] ty, input logic t);
    tick();
    chk({tag, ".so_state"}, state, SO);
    chk({tag, ".so_hrq"}, hrq, 1);
    chk({tag, ".so_dack"}, dack, 4'b0000);
    tick();
    chk({tag, ".s1_state"}, state, S1);
    chk({tag, ".s1_aen_adstb"}, {aen, adstb}, 2'b11);
    chk({tag, ".s1_dack"}, dack, d);
    tick();
    chk({tag, ".s2_state"}, state, S2);
    chk({tag, ".s2_strb"}, {ior_n, iow_n, memr_n, memw_n}, exp_strb(ty, 0));
    chk({tag, ".s2_adstb"}, adstb, 0);
    tick();
    chk({tag, ".s3_state"}, state, S3);
    chk({tag, ".s3_strb"}, {ior_n, iow_n, memr_n, memw_n}, exp_strb(ty, 1));
    tick();
    chk({tag, ".s4_state"}, state, S4);
    chk({tag, ".s4_tc"}, tc, t);
    chk({tag, ".s4_strb"}, {ior_n, iow_n, memr_n, memw_n}, 4'b1111);
    chk({tag, ".s4_dack_aen"}, {dack, aen}, {d, 1'b1});
    tick();
    chk({tag, ".si_state"}, state, SI);
    chk({tag, ".si_idle"}, {hrq, aen, tc, dack}, 7'b0);
  endtask

  initial begin
    reset_n = 1'b0; cs_n = 1'b1; hlda = 1'b1; ready = 1'b1;
    dreq = 4'b0000; ch_mask = 4'b0000; xfer_type = 8'b01_00_01_10;
    cnt_ld = 1'b0; cnt_sel = 2'd0; cnt_data = 16'd0;

    // Reset state
    tick(); tick();
    chk("rst_state", state, SI);
    chk("rst_ctl", {hrq, aen, adstb, tc, dack}, 8'b0);
    chk("rst_strb", {ior_n, iow_n, memr_n, memw_n}, 4'b1111);
    reset_n = 1'b1;
    cs_n = 1'b0;

    // Ch1 loaded with 2 -> three write transfers, TC on the third
    load(2'd1, 16'd2);
    dreq = 4'b0010;
    xfer("w1", 4'b0010, 2'b01, 1'b0);
    xfer("w2", 4'b0010, 2'b01, 1'b0);
    xfer("w3", 4'b0010, 2'b01, 1'b1);
    tick();
    chk("done_idle", state, SI);

    // Controller disabled: pending channel must not start
    cs_n = 1'b1;
    load(2'd1, 16'd0);
    tick();
    chk("csn_idle", {state, hrq}, {SI, 1'b0});

    // Priority among ch1..ch3
    load(2'd1, 16'd5);
    cs_n = 1'b0;
    dreq = 4'b1110;
    xfer("pri1", 4'b0010, 2'b01, 1'b0);
    if (ROT) xfer("pri2", 4'b0100, 2'b00, 1'b1);
    else     xfer("pri2", 4'b0010, 2'b01, 1'b0);
    dreq = 4'b0000;

    // Masked channel is ignored
    ch_mask = 4'b0001;
    dreq = 4'b0001;
    tick();
    chk("mask_idle", state, SI);
    dreq = 4'b0000;
    ch_mask = 4'b0000;

    // READY low for three S3 cycles on a read transfer, ch0 count 1
    load(2'd0, 16'd1);
    dreq = 4'b0001;
    tick(); tick(); tick();
    chk("rdy_s2", {state, ior_n, iow_n, memr_n, memw_n}, {S2, 4'b1101});
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rdy_s3_%0d", k), {state, ior_n, iow_n, memr_n, memw_n}, {S3, 4'b1001});
    end
    ready = 1'b1;
    tick();
    chk("rdy_s4", {state, tc}, {S4, 1'b0});
    tick();
    xfer("rdy_next", 4'b0001, 2'b10, 1'b1);
    dreq = 4'b0000;

    // HLDA drops in S2 -> abort, counter untouched
    load(2'd3, 16'd0);
    dreq = 4'b1000;
    tick(); tick(); tick();
    chk("abort_s2", {state, ior_n, iow_n, memr_n, memw_n}, {S2, 4'b0111});
    hlda = 1'b0;
    tick();
    chk("abort_state", state, SI);
    chk("abort_out", {hrq, aen, adstb, tc, dack, ior_n, iow_n, memr_n, memw_n}, {8'b0, 4'b1111});
    hlda = 1'b1;
    xfer("abort_next", 4'b1000, 2'b01, 1'b1);
    dreq = 4'b0000;

    // Load of ch0 to 5 in the same cycle as ch0's S4
    load(2'd0, 16'd0);
    dreq = 4'b0001;
    tick(); tick(); tick(); tick(); tick();
    chk("ldwin_s4", {state, tc}, {S4, 1'b1});
    cnt_ld = 1'b1; cnt_sel = 2'd0; cnt_data = 16'd5;
    tick();
    cnt_ld = 1'b0;
    chk("ldwin_si", state, SI);
    for (int k = 0; k < 6; k++) begin
      xfer($sformatf("ldwin_x%0d", k), 4'b0001, 2'b10, (k == 5));
    end
    dreq = 4'b0000;

    // Reset asserted in S3
    load(2'd1, 16'd4);
    dreq = 4'b0010;
    tick(); tick(); tick(); tick();
    chk("rst3_s3", state, S3);
    reset_n = 1'b0;
    tick();
    chk("rst3_state", state, SI);
    chk("rst3_out", {hrq, aen, adstb, tc, dack, ior_n, iow_n, memr_n, memw_n}, {8'b0, 4'b1111});
    reset_n = 1'b1;
    xfer("rst3_cnt0", 4'b0010, 2'b01, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
